// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: request flag encodings,
// FSM states, arbitration mode constants and a width helper.
package mem_arbiter_pkg;

  // Request flag encodings, {write, read}. 2'b11 is serviced as a write.
  localparam logic [1:0] FLAG_IDLE = 2'b00;
  localparam logic [1:0] FLAG_RD   = 2'b01;
  localparam logic [1:0] FLAG_WR   = 2'b10;

  // Arbitration mode, as seen by the selector.
  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // Ceiling log2, never below 1 so that index/counter vectors stay legal.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selector: round-robin starting at ptr_i, or fixed
// priority with channel 0 highest. Returns the one-hot grant and its index.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int CH_NUM = 2,
  localparam int GW = clog2_min1(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req_i,
  input  logic [GW-1:0]     ptr_i,
  input  logic              mode_i,
  output logic [CH_NUM-1:0] grant_oh_o,
  output logic [GW-1:0]     grant_idx_o,
  output logic              valid_o
);

  // Pick the requester with the smallest distance from the start position.
  always_comb begin
    int p;
    int off;
    int sel;
    int best_off;
    logic better;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    sel         = -1;
    best_off    = CH_NUM;
    off         = 0;
    better      = 1'b0;
    // An out-of-range pointer (non power-of-two CH_NUM) restarts at channel 0.
    p = (int'(ptr_i) < CH_NUM) ? int'(ptr_i) : 0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (mode_i == ARB_FIXED) begin
        off = k;
      end else begin
        off = (k >= p) ? (k - p) : (k + CH_NUM - p);
      end
      better   = req_i[k] && (off < best_off);
      sel      = better ? k : sel;
      best_off = better ? off : best_off;
    end
    valid_o     = (sel >= 0);
    grant_idx_o = valid_o ? GW'(sel) : '0;
    for (int k = 0; k < CH_NUM; k++) begin
      grant_oh_o[k] = (sel == k);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-port arbiter. One transaction at a time moves through
// IDLE -> WAIT -> RESP; all outputs are registered. A watchdog turns a
// memory that never completes into an error completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CH_NUM   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*CH_NUM-1:0]          ch_rw_flag_i,
  input  logic [ADDR_W*CH_NUM-1:0]     ch_addr_i,
  input  logic [DATA_W*CH_NUM-1:0]     ch_w_data_i,
  input  logic [(DATA_W/8)*CH_NUM-1:0] ch_w_mask_i,
  output logic [DATA_W*CH_NUM-1:0]     ch_r_data_o,
  output logic [CH_NUM-1:0]            ch_busy_o,
  output logic [CH_NUM-1:0]            ch_done_o,
  output logic [CH_NUM-1:0]            ch_err_o,
  output logic [1:0]                   mem_rw_flag_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_w_data_o,
  output logic [DATA_W/8-1:0]          mem_w_mask_o,
  input  logic [DATA_W-1:0]            mem_r_data_i,
  input  logic                         mem_busy_i,
  input  logic                         mem_done_i
);

  localparam int   MW     = DATA_W / 8;
  localparam int   GW     = clog2_min1(CH_NUM);
  localparam int   WDW    = clog2_min1(TIMEOUT + 1);
  localparam logic MODE_L = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  arb_state_e         state_q;
  logic [GW-1:0]      grant_q;
  logic [CH_NUM-1:0]  grant_oh_q;
  logic [GW-1:0]      ptr_q;
  logic [WDW-1:0]     wdog_q;
  logic [1:0]         mem_rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MW-1:0]      wmask_q;
  logic [CH_NUM-1:0]  ch_busy_q;
  logic [CH_NUM-1:0]  ch_done_q;
  logic [CH_NUM-1:0]  ch_err_q;
  logic [DATA_W-1:0]  rdata_q [CH_NUM];

  logic [CH_NUM-1:0]  req_s;
  logic [1:0]         flag_s  [CH_NUM];
  logic [ADDR_W-1:0]  addr_s  [CH_NUM];
  logic [DATA_W-1:0]  wdata_s [CH_NUM];
  logic [MW-1:0]      wmask_s [CH_NUM];
  logic [CH_NUM-1:0]  pick_oh_s;
  logic [GW-1:0]      pick_idx_s;
  logic               pick_valid_s;
  logic [WDW-1:0]     wdog_inc_s;
  logic [GW-1:0]      ptr_next_s;
  logic               mem_busy_unused_s;

  // mem_busy_i carries no control meaning for the arbiter.
  assign mem_busy_unused_s = mem_busy_i;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign flag_s[k]  = ch_rw_flag_i[2*k +: 2];
    assign req_s[k]   = |ch_rw_flag_i[2*k +: 2];
    assign addr_s[k]  = ch_addr_i[ADDR_W*k +: ADDR_W];
    assign wdata_s[k] = ch_w_data_i[DATA_W*k +: DATA_W];
    assign wmask_s[k] = ch_w_mask_i[MW*k +: MW];
    assign ch_r_data_o[DATA_W*k +: DATA_W] = rdata_q[k];
  end

  arb_pick #(
    .CH_NUM (CH_NUM)
  ) u_pick (
    .req_i       (req_s),
    .ptr_i       (ptr_q),
    .mode_i      (MODE_L),
    .grant_oh_o  (pick_oh_s),
    .grant_idx_o (pick_idx_s),
    .valid_o     (pick_valid_s)
  );

  assign wdog_inc_s = wdog_q + WDW'(1);
  assign ptr_next_s = (grant_q == GW'(CH_NUM - 1)) ? '0 : (grant_q + GW'(1));

  assign mem_rw_flag_o = mem_rw_q;
  assign mem_addr_o    = addr_q;
  assign mem_w_data_o  = wdata_q;
  assign mem_w_mask_o  = wmask_q;
  assign ch_busy_o     = ch_busy_q;
  assign ch_done_o     = ch_done_q;
  assign ch_err_o      = ch_err_q;

  // Arbitration FSM with registered memory-side and channel-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      ptr_q      <= '0;
      wdog_q     <= '0;
      mem_rw_q   <= FLAG_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ch_busy_q  <= '0;
      ch_done_q  <= '0;
      ch_err_q   <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        rdata_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          ch_done_q <= '0;
          ch_err_q  <= '0;
          wdog_q    <= '0;
          if (pick_valid_s) begin
            grant_q    <= pick_idx_s;
            grant_oh_q <= pick_oh_s;
            addr_q     <= addr_s[pick_idx_s];
            wdata_q    <= wdata_s[pick_idx_s];
            wmask_q    <= wmask_s[pick_idx_s];
            mem_rw_q   <= flag_s[pick_idx_s][1] ? FLAG_WR : FLAG_RD;
            ch_busy_q  <= pick_oh_s;
            state_q    <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A completion in the expiry cycle takes precedence over the error.
          if (mem_done_i) begin
            rdata_q[grant_q] <= (mem_rw_q == FLAG_WR) ? '0 : mem_r_data_i;
            mem_rw_q         <= FLAG_IDLE;
            ch_done_q        <= grant_oh_q;
            ch_err_q         <= '0;
            ch_busy_q        <= '0;
            state_q          <= ST_RESP;
          end else if ((TIMEOUT != 0) && (wdog_inc_s == WDW'(TIMEOUT))) begin
            rdata_q[grant_q] <= '0;
            mem_rw_q         <= FLAG_IDLE;
            ch_done_q        <= grant_oh_q;
            ch_err_q         <= grant_oh_q;
            ch_busy_q        <= '0;
            state_q          <= ST_RESP;
          end else begin
            wdog_q <= wdog_inc_s;
          end
        end
        ST_RESP: begin
          ch_done_q <= '0;
          ch_err_q  <= '0;
          if (MODE_L == ARB_RR) begin
            ptr_q <= ptr_next_s;
          end else begin
            ptr_q <= '0;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          mem_rw_q  <= FLAG_IDLE;
          ch_busy_q <= '0;
          ch_done_q <= '0;
          ch_err_q  <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin instance (long watchdog) and a fixed-priority
// instance (TIMEOUT=4) share the same stimulus; each task checks one of them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_rw;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [7:0]  ch_wmask;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_done;

  logic [63:0] rr_r_data, fx_r_data;
  logic [1:0]  rr_busy, rr_done, rr_err, fx_busy, fx_done, fx_err;
  logic [1:0]  rr_mem_rw, fx_mem_rw;
  logic [31:0] rr_mem_addr, fx_mem_addr, rr_mem_wdata, fx_mem_wdata;
  logic [3:0]  rr_mem_wmask, fx_mem_wmask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.CH_NUM(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(255)) u_rr (
    .clk(clk), .rst(rst), .ch_rw_flag_i(ch_rw), .ch_addr_i(ch_addr),
    .ch_w_data_i(ch_wdata), .ch_w_mask_i(ch_wmask), .ch_r_data_o(rr_r_data),
    .ch_busy_o(rr_busy), .ch_done_o(rr_done), .ch_err_o(rr_err),
    .mem_rw_flag_o(rr_mem_rw), .mem_addr_o(rr_mem_addr), .mem_w_data_o(rr_mem_wdata),
    .mem_w_mask_o(rr_mem_wmask), .mem_r_data_i(mem_rdata), .mem_busy_i(mem_busy),
    .mem_done_i(mem_done)
  );

  mem_arbiter #(.CH_NUM(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(4)) u_fx (
    .clk(clk), .rst(rst), .ch_rw_flag_i(ch_rw), .ch_addr_i(ch_addr),
    .ch_w_data_i(ch_wdata), .ch_w_mask_i(ch_wmask), .ch_r_data_o(fx_r_data),
    .ch_busy_o(fx_busy), .ch_done_o(fx_done), .ch_err_o(fx_err),
    .mem_rw_flag_o(fx_mem_rw), .mem_addr_o(fx_mem_addr), .mem_w_data_o(fx_mem_wdata),
    .mem_w_mask_o(fx_mem_wmask), .mem_r_data_i(mem_rdata), .mem_busy_i(mem_busy),
    .mem_done_i(mem_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_rw = 4'b0000; ch_addr = 64'h0; ch_wdata = 64'h0; ch_wmask = 8'h00;
    mem_rdata = 32'h0; mem_busy = 1'b0; mem_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ch_rw = 4'b0101; rst = 1'b0;
    tick();
    do_reset();
    checks++; if (rr_mem_rw !== 2'b00) begin failures++; $display("FAIL reset_mem_rw got=%h exp=%h", rr_mem_rw, 2'b00); end
    checks++; if (rr_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%h exp=%h", rr_busy, 2'b00); end
    checks++; if (rr_done !== 2'b00) begin failures++; $display("FAIL reset_done got=%h exp=%h", rr_done, 2'b00); end
    checks++; if (rr_err !== 2'b00) begin failures++; $display("FAIL reset_err got=%h exp=%h", rr_err, 2'b00); end
    checks++; if (rr_r_data !== 64'h0) begin failures++; $display("FAIL reset_r_data got=%h exp=%h", rr_r_data, 64'h0); end
    checks++; if (rr_mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=%h", rr_mem_addr, 32'h0); end
    checks++; if (fx_mem_rw !== 2'b00) begin failures++; $display("FAIL reset_fx_mem_rw got=%h exp=%h", fx_mem_rw, 2'b00); end
  endtask

  task automatic test_single_read();
    do_reset();
    ch_rw = 4'b0100; ch_addr = {32'h0000_0100, 32'h0};
    tick();
    checks++; if (rr_busy !== 2'b10) begin failures++; $display("FAIL rd_busy got=%h exp=%h", rr_busy, 2'b10); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rr_mem_rw !== 2'b01) begin failures++; $display("FAIL rd_mem_rw cyc=%0d got=%h exp=%h", i, rr_mem_rw, 2'b01); end
      checks++; if (rr_mem_addr !== 32'h100) begin failures++; $display("FAIL rd_mem_addr cyc=%0d got=%h exp=%h", i, rr_mem_addr, 32'h100); end
      if (i == 3) begin mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    mem_done = 1'b0; mem_rdata = 32'h0;
    checks++; if (rr_mem_rw !== 2'b00) begin failures++; $display("FAIL rd_mem_rw_drop got=%h exp=%h", rr_mem_rw, 2'b00); end
    checks++; if (rr_done !== 2'b10) begin failures++; $display("FAIL rd_done got=%h exp=%h", rr_done, 2'b10); end
    checks++; if (rr_r_data[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=%h", rr_r_data[63:32], 32'hDEAD_BEEF); end
    checks++; if (rr_err !== 2'b00) begin failures++; $display("FAIL rd_err got=%h exp=%h", rr_err, 2'b00); end
    checks++; if (rr_busy !== 2'b00) begin failures++; $display("FAIL rd_busy_resp got=%h exp=%h", rr_busy, 2'b00); end
    ch_rw = 4'b0000;
    tick();
    checks++; if (rr_done !== 2'b00) begin failures++; $display("FAIL rd_done_pulse got=%h exp=%h", rr_done, 2'b00); end
    checks++; if (rr_r_data[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data_hold got=%h exp=%h", rr_r_data[63:32], 32'hDEAD_BEEF); end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_oh;
    do_reset();
    ch_rw = 4'b0101; ch_addr = {32'h0000_0200, 32'h0000_0300};
    for (int n = 0; n < 4; n++) begin
      exp_oh = ((n % 2) == 0) ? 2'b01 : 2'b10;
      tick();
      checks++; if (rr_busy !== exp_oh) begin failures++; $display("FAIL rr_grant n=%0d got=%h exp=%h", n, rr_busy, exp_oh); end
      checks++; if (rr_mem_rw !== 2'b01) begin failures++; $display("FAIL rr_mem_rw n=%0d got=%h exp=%h", n, rr_mem_rw, 2'b01); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      checks++; if (rr_done !== exp_oh) begin failures++; $display("FAIL rr_done n=%0d got=%h exp=%h", n, rr_done, exp_oh); end
      checks++; if (rr_mem_rw !== 2'b00) begin failures++; $display("FAIL rr_gap1 n=%0d got=%h exp=%h", n, rr_mem_rw, 2'b00); end
      tick();
      checks++; if (rr_mem_rw !== 2'b00) begin failures++; $display("FAIL rr_gap2 n=%0d got=%h exp=%h", n, rr_mem_rw, 2'b00); end
      checks++; if (rr_done !== 2'b00) begin failures++; $display("FAIL rr_done_clr n=%0d got=%h exp=%h", n, rr_done, 2'b00); end
    end
    ch_rw = 4'b0000;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    ch_rw = 4'b0101; ch_addr = {32'h0000_0200, 32'h0000_0300};
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (fx_busy !== 2'b01) begin failures++; $display("FAIL fx_grant n=%0d got=%h exp=%h", n, fx_busy, 2'b01); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      checks++; if (fx_done !== 2'b01) begin failures++; $display("FAIL fx_done n=%0d got=%h exp=%h", n, fx_done, 2'b01); end
      tick();
    end
    ch_rw = 4'b0100;
    tick();
    checks++; if (fx_busy !== 2'b10) begin failures++; $display("FAIL fx_grant_ch1 got=%h exp=%h", fx_busy, 2'b10); end
    checks++; if (fx_mem_addr !== 32'h200) begin failures++; $display("FAIL fx_addr_ch1 got=%h exp=%h", fx_mem_addr, 32'h200); end
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checks++; if (fx_done !== 2'b10) begin failures++; $display("FAIL fx_done_ch1 got=%h exp=%h", fx_done, 2'b10); end
    ch_rw = 4'b0000;
    tick();
  endtask

  task automatic test_write_mask();
    do_reset();
    ch_rw = 4'b0001; ch_addr = {32'h0, 32'h0000_0040};
    tick();
    mem_done = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    tick();
    mem_done = 1'b0; mem_rdata = 32'h0;
    checks++; if (rr_r_data[31:0] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_pre_read got=%h exp=%h", rr_r_data[31:0], 32'hA5A5_A5A5); end
    ch_rw = 4'b0000;
    tick();
    ch_rw = 4'b0011; ch_wdata = {32'h0, 32'h1234_5678}; ch_wmask = 8'h03;
    tick();
    checks++; if (rr_mem_rw !== 2'b10) begin failures++; $display("FAIL wr_mem_rw got=%h exp=%h", rr_mem_rw, 2'b10); end
    checks++; if (rr_mem_wmask !== 4'b0011) begin failures++; $display("FAIL wr_mask got=%h exp=%h", rr_mem_wmask, 4'b0011); end
    checks++; if (rr_mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_data got=%h exp=%h", rr_mem_wdata, 32'h1234_5678); end
    checks++; if (rr_busy !== 2'b01) begin failures++; $display("FAIL wr_busy got=%h exp=%h", rr_busy, 2'b01); end
    mem_done = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_done = 1'b0; mem_rdata = 32'h0;
    checks++; if (rr_done !== 2'b01) begin failures++; $display("FAIL wr_done got=%h exp=%h", rr_done, 2'b01); end
    checks++; if (rr_r_data[31:0] !== 32'h0) begin failures++; $display("FAIL wr_r_data got=%h exp=%h", rr_r_data[31:0], 32'h0); end
    ch_rw = 4'b0000;
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    ch_rw = 4'b0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (fx_mem_rw !== 2'b01) begin failures++; $display("FAIL wd_mem_rw cyc=%0d got=%h exp=%h", i, fx_mem_rw, 2'b01); end
      tick();
    end
    checks++; if (fx_mem_rw !== 2'b00) begin failures++; $display("FAIL wd_mem_rw_drop got=%h exp=%h", fx_mem_rw, 2'b00); end
    checks++; if (fx_done !== 2'b01) begin failures++; $display("FAIL wd_done got=%h exp=%h", fx_done, 2'b01); end
    checks++; if (fx_err !== 2'b01) begin failures++; $display("FAIL wd_err got=%h exp=%h", fx_err, 2'b01); end
    ch_rw = 4'b0000;
    tick();
    checks++; if (fx_err !== 2'b00) begin failures++; $display("FAIL wd_err_pulse got=%h exp=%h", fx_err, 2'b00); end
    ch_rw = 4'b0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (fx_mem_rw !== 2'b01) begin failures++; $display("FAIL wdt_mem_rw cyc=%0d got=%h exp=%h", i, fx_mem_rw, 2'b01); end
      if (i == 3) begin mem_done = 1'b1; mem_rdata = 32'h0000_0055; end
      tick();
    end
    mem_done = 1'b0; mem_rdata = 32'h0;
    checks++; if (fx_done !== 2'b01) begin failures++; $display("FAIL wdt_done got=%h exp=%h", fx_done, 2'b01); end
    checks++; if (fx_err !== 2'b00) begin failures++; $display("FAIL wdt_err got=%h exp=%h", fx_err, 2'b00); end
    checks++; if (fx_r_data[31:0] !== 32'h0000_0055) begin failures++; $display("FAIL wdt_r_data got=%h exp=%h", fx_r_data[31:0], 32'h0000_0055); end
    ch_rw = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ch_rw = 4'b0001;
    tick();
    mem_done = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_done = 1'b0; mem_rdata = 32'h0;
    ch_rw = 4'b0000;
    tick();
    ch_rw = 4'b0101;
    tick();
    checks++; if (rr_busy !== 2'b10) begin failures++; $display("FAIL rst_pre_grant got=%h exp=%h", rr_busy, 2'b10); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rr_mem_rw !== 2'b00) begin failures++; $display("FAIL rst_mem_rw got=%h exp=%h", rr_mem_rw, 2'b00); end
    checks++; if (rr_busy !== 2'b00) begin failures++; $display("FAIL rst_busy got=%h exp=%h", rr_busy, 2'b00); end
    checks++; if (rr_done !== 2'b00) begin failures++; $display("FAIL rst_done got=%h exp=%h", rr_done, 2'b00); end
    checks++; if (rr_r_data !== 64'h0) begin failures++; $display("FAIL rst_r_data got=%h exp=%h", rr_r_data, 64'h0); end
    tick();
    checks++; if (rr_done !== 2'b00) begin failures++; $display("FAIL rst_no_done got=%h exp=%h", rr_done, 2'b00); end
    checks++; if (rr_busy !== 2'b01) begin failures++; $display("FAIL rst_ptr_grant got=%h exp=%h", rr_busy, 2'b01); end
    ch_rw = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; ch_rw = 4'b0000; ch_addr = 64'h0; ch_wdata = 64'h0; ch_wmask = 8'h00;
    mem_rdata = 32'h0; mem_busy = 1'b0; mem_done = 1'b0;
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_write_mask();
    test_watchdog();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel memory-port arbiter. It merges CH_NUM cache-side memory requesters (icache, dcache, future channels) onto one shared memory port.
- Sits between the cache instances' mem_* interfaces and the single external memory controller. This replaces the fixed two-channel packed bus at cpu top.
- Adds round-robin or fixed-priority arbitration, a per-transaction watchdog, and registered responses.

Parameters:
- CH_NUM, 2: number of requesting channels (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; the mask width is DATA_W/8.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, channel 0 highest.
- TIMEOUT, 255: maximum number of cycles in WAIT before an error completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ch_rw_flag_i  in  2*CH_NUM  per channel {write, read}; bits [2k+1:2k] belong to channel k.
- ch_addr_i  in  ADDR_W*CH_NUM  per-channel address.
- ch_w_data_i  in  DATA_W*CH_NUM  per-channel write data.
- ch_w_mask_i  in  (DATA_W/8)*CH_NUM  per-channel byte mask.
- ch_r_data_o  out  DATA_W*CH_NUM  per-channel read data; valid in the cycle done is high.
- ch_busy_o  out  CH_NUM  channel k has an accepted transaction in flight.
- ch_done_o  out  CH_NUM  one-cycle completion pulse.
- ch_err_o  out  CH_NUM  one-cycle pulse together with done on a watchdog expiry.
- mem_rw_flag_o  out  2  request to memory, {write, read}.
- mem_addr_o  out  ADDR_W  memory address.
- mem_w_data_o  out  DATA_W  memory write data.
- mem_w_mask_o  out  DATA_W/8  memory byte mask.
- mem_r_data_i  in  DATA_W  memory read data.
- mem_busy_i  in  1  memory is busy.
- mem_done_i  in  1  memory completion pulse.

Behaviour:
- Reset (rst=1 at a clock edge) forces every output to 0, state IDLE, RR pointer 0 and watchdog count 0. Reset mid-transaction drops mem_rw_flag_o the next cycle; no done or err is issued for the aborted transaction.
- A channel is requesting when its rw_flag != 2'b00. Flag 2'b11 is treated as a write. A requester holds its flag until it sees done.
- States are IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any channel is requesting, select the winner: RR = first requester at or after ptr, wrapping modulo CH_NUM; fixed = lowest index.
  - Latch the winner's grant index, addr, w_data, w_mask and op. Go to WAIT.
  - ch_busy_o[grant] rises in the same edge.
- WAIT:
  - mem_* outputs are driven from the latched registers. mem_rw_flag_o is held until the cycle mem_done_i is sampled high.
  - Channel inputs are ignored. A channel dropping or changing its request does not affect the in-flight transaction.
  - mem_busy_i is informational only. The watchdog increments every WAIT cycle.
  - On mem_done_i: capture mem_r_data_i (reads only; 0 for writes), clear mem_rw_flag_o, go to RESP.
  - If TIMEOUT != 0 and the count reaches TIMEOUT with no mem_done_i: clear mem_rw_flag_o, set the err flag, go to RESP with r_data 0.
  - If mem_done_i and expiry occur in the same cycle, done wins and err is not set.
- RESP (one cycle):
  - ch_done_o[grant] = 1. ch_r_data_o[grant] holds the captured data, and holds it until that channel's next completion.
  - ch_err_o[grant] pulses if the err flag is set. ch_busy_o[grant] = 0.
  - In RR mode, ptr = (grant+1) mod CH_NUM. Go to IDLE.
- The mem_rw_flag_o gap is at least 2 cycles between transactions (RESP plus the IDLE decision cycle), so memory always sees the request deassert.
- Latency: a request sampled in IDLE at edge t is driven on mem_rw_flag_o after edge t. With mem_done_i sampled at edge t+n, ch_done_o is high during cycle t+n+1.
- ch_done_o, ch_err_o and ch_busy_o are one-hot or zero at all times.
- CH_NUM=1: the arbiter reduces to a registered pass-through with the same state sequence.

Decomposition:
- Shared package/header mem_arb_defs.vh holds:
  - RW flag encodings: FLAG_IDLE=2'b00, FLAG_RD=2'b01, FLAG_WR=2'b10.
  - State encodings.
  - An ARB_RR/ARB_FIXED mode constant.
  - A clog2 macro for the grant and watchdog widths.
- One sub-module, arb_pick: a combinational priority/round-robin selector taking req[CH_NUM], ptr and mode, and returning the one-hot grant and its index. It is testable in isolation.

Test Plan:
- Single read: CH_NUM=2, ch1 read addr 0x100; memory returns 0xDEADBEEF after 3 cycles.
  - Required: mem_rw_flag_o=01 and mem_addr_o=0x100 for 4 cycles.
  - Required: ch_done_o=2'b10 one cycle after mem_done_i, with ch_r_data_o[63:32]=0xDEADBEEF and ch_err_o=0.
- RR fairness: both channels request continuously, ARB_MODE=0.
  - Required grant sequence 0,1,0,1; each done is one-hot; at least a 2-cycle gap on mem_rw_flag_o between transactions.
- Fixed priority: same stimulus as the RR fairness test with ARB_MODE=1.
  - Required: ch0 served every time; ch1 is served only after ch0 drops its request.
- Write with mask: ch0 flag=11 (treated as write), w_data 0x12345678, mask 4'b0011.
  - Required: mem_rw_flag_o=10, mem_w_mask_o=0011 and mem_w_data_o=0x12345678; ch_r_data_o for ch0 updates to 0.
- Watchdog: TIMEOUT=4; memory never asserts done.
  - Required: mem_rw_flag_o deasserts after 4 WAIT cycles; ch_done_o and ch_err_o pulse together for the granted channel.
  - Repeat with mem_done_i arriving on the expiry cycle: required err=0.
- Reset mid-WAIT: assert rst during WAIT.
  - Required: all outputs 0 the next cycle, no done for the aborted transaction, ptr back to 0 (ch0 granted first afterwards).
